dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 87 ++++++++
 tb/tb_dmem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Single-port data memory with byte-lane writes, 1-cycle response latency,
// range checking and an optional zero-fill sweep after reset.
module dmem_ctrl #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   clr_cnt, clr_cnt_next;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               in_range;
    logic               wr_en;
    logic [IDX_W-1:0]   idx;

    always_comb begin
        req_ready = reset && (state == IDLE);
        busy      = reset ? (state == CLEAR) : (CLEAR_ON_RESET != 0);
        accept    = req_valid && req_ready;
        in_range  = {1'b0, req_addr} < DEPTH_L;
        wr_en     = accept && req_we && in_range;
        idx       = req_addr[IDX_W-1:0];
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_next = clr_cnt + IDX_W'(1);
            if (clr_cnt == LAST) begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            rsp_valid <= accept;
            rsp_err   <= accept && !in_range;
            rsp_rdata <= (accept && !req_we && in_range) ? mem[idx] : '0;
        end
    end

    // Memory has no reset: contents survive reset and only the sweep clears them.
    always_ff @(posedge clk) begin
        if (reset && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed-vector bench for dmem_ctrl with DATA_W=32, DEPTH=16, CLEAR_ON_RESET=1.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int vec_cnt;
    int err_cnt;

    dmem_ctrl #(
        .DATA_W(32),
        .DEPTH(16),
        .ADDR_W(32),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    // One request; returns the response seen one cycle after acceptance.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        idle_inputs();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    // Counts cycles with busy high after reset release, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          n;

    logic        bb_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] bb_addr [4] = '{32'd1, 32'd1, 32'd2, 32'd2};
    logic [31:0] bb_data [4] = '{32'h1, 32'h0, 32'h2, 32'h0};

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);

        reset = 1'b1;
        count_busy(n);
        check("clear_cycles", 32'(n), 32'd16);
        check("ready_after_clear", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int a = 0; a < 16; a++) begin
            xact(1'b0, 32'(a), 32'h0, 4'hF, rd, er);
            check("clr_read", rd, 32'h0);
            if (er) check("clr_err", 32'(er), 32'd0);
        end

        xact(1'b1, 32'd3, 32'hDEADBEEF, 4'hF, rd, er);
        check("wr3_rdata", rd, 32'h0);
        check("wr3_err", 32'(er), 32'd0);
        xact(1'b0, 32'd3, 32'h0, 4'h0, rd, er);
        check("rd3", rd, 32'hDEADBEEF);

        xact(1'b1, 32'd5, 32'h11223344, 4'hF, rd, er);
        xact(1'b1, 32'd5, 32'hAABBCCDD, 4'b0101, rd, er);
        xact(1'b0, 32'd5, 32'h0, 4'hF, rd, er);
        check("rd5_lanes", rd, 32'h11BB33DD);
        xact(1'b1, 32'd5, 32'hFFFFFFFF, 4'b0000, rd, er);
        xact(1'b0, 32'd5, 32'h0, 4'h0, rd, er);
        check("rd5_be0", rd, 32'h11BB33DD);
        xact(1'b0, 32'd3, 32'h12345678, 4'hF, rd, er);
        check("rd3_ignores_wdata", rd, 32'hDEADBEEF);

        xact(1'b1, 32'd16, 32'hFFFFFFFF, 4'hF, rd, er);
        check("wr16_err", 32'(er), 32'd1);
        check("wr16_rdata", rd, 32'h0);
        xact(1'b0, 32'd0, 32'h0, 4'hF, rd, er);
        check("rd0_no_alias", rd, 32'h0);
        check("rd0_err", 32'(er), 32'd0);
        xact(1'b0, 32'd20, 32'h0, 4'hF, rd, er);
        check("rd20_err", 32'(er), 32'd1);
        check("rd20_rdata", rd, 32'h0);
        tick();
        check("err_clears", 32'(rsp_err), 32'd0);

        // Back-to-back stream; each response is checked while the next request is driven.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                check("b2b_ready", 32'(req_ready), 32'd1);
                req_valid = 1'b1;
                req_we    = bb_we[i];
                req_addr  = bb_addr[i];
                req_wdata = bb_data[i];
                req_be    = 4'hF;
            end else begin
                idle_inputs();
            end
            if (i > 0) begin
                check("b2b_valid", 32'(rsp_valid), 32'd1);
                if (!bb_we[i-1]) check("b2b_rdata", rsp_rdata, bb_data[i-2]);
            end
            tick();
        end
        idle_inputs();
        check("b2b_done", 32'(rsp_valid), 32'd0);

        // Reset with a response pending drops it.
        req_valid = 1'b1;
        req_addr  = 32'd3;
        tick();
        idle_inputs();
        check("pend_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        tick();
        check("pend_dropped", 32'(rsp_valid), 32'd0);
        check("pend_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;

        // Requests during the sweep are ignored; reset at count 7 restarts it.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd0;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        for (int i = 0; i < 7; i++) begin
            check("clr_ready", 32'(req_ready), 32'd0);
            tick();
            check("clr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        check("midclr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        count_busy(n);
        check("restart_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            xact(1'b0, 32'(a), 32'h0, 4'hF, rd, er);
            check("reclr_read", rd, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
